apb_sent_regbank: RTL and testbench
===================================

# apb_sent_regbank

Parametrised APB3 register bank for the SAE J2716 (SENT) controller. It serves CHANNELS independent SENT channels from one APB slave port. It adds PREADY wait-state back-pressure on full TX / empty RX paths, PSLVERR error reporting, and per-channel maskable interrupt status with write-1-to-clear. It sits between the system APB bus and the per-channel TX/RX FIFOs and frame engines.

## Interface
- ADDRESSWIDTH, 8: PADDR width; PADDR[3:0] = register offset, PADDR[ADDRESSWIDTH-1:4] = channel index
- DATAWIDTH, 24: PWDATA/PRDATA width (≥24)
- CHANNELS, 2: number of SENT channels, 1..8
- WAIT_MAX, 15: maximum stall cycles before a blocked TX/RX access errors out (1..255)

Ports (channel c occupies slice [c*W +: W] of every packed bus):
- PCLK  in  1  clock, all logic on rising edge
- PRESET  in  1  reset; synchronous, active-high
- PADDR  in  ADDRESSWIDTH  word address
- PWDATA  in  DATAWIDTH  write data
- PWRITE, PSELx, PENABLE  in  1 each  APB control
- PRDATA  out  DATAWIDTH  read data, zero-extended
- PREADY  out  1  transfer complete
- PSLVERR  out  1  error, valid only while PREADY=1
- reg_command  out  CHANNELS*8  per-channel command register
- reg_status  in  CHANNELS*8  per-channel status
- tx_data  out  CHANNELS*12  data presented with tx_push
- tx_push  out  CHANNELS  one-cycle TX FIFO write strobe
- tx_full  in  CHANNELS  TX FIFO full
- rx_data  in  CHANNELS*12  RX FIFO head
- rx_empty  in  CHANNELS  RX FIFO empty
- rx_pop  out  CHANNELS  one-cycle RX FIFO read strobe
- reg_id_data  out  CHANNELS*24  ID/data to transmit
- reg_id_data_rv  in  CHANNELS*24  received ID/data
- reg_format_rv  in  CHANNELS*8  received format
- ch_event  in  CHANNELS*8  event pulses, one bit per event source
- irq  out  1  OR of all unmasked pending events, registered

## Operation
- Offsets: 0 COMMAND RW[7:0]; 1 STATUS RO; 2 TX WO[11:0] (push); 3 RX RO (pop); 4 ID_DATA RW[23:0]; 5 ID_RV RO; 6 FORMAT_RV RO; 7 IRQ_STATUS RW1C[7:0]; 8 IRQ_MASK RW[7:0]; 9–15 unmapped.
- Errors (PSLVERR=1, no side effect, PRDATA=0 on reads): channel index ≥ CHANNELS; unmapped offset; write to RO offset; read of TX; stall timeout.
- FSM IDLE/ACCESS/RESP:
  - IDLE: PSELx & !PENABLE → ACCESS.
  - ACCESS: requires PSELx & PENABLE, else → IDLE with no side effects (protocol abort).
    - Stall condition: TX write with tx_full[c]=1, or RX read with rx_empty[c]=1. While stalled, increment wait counter and remain in ACCESS. When the counter reaches WAIT_MAX, complete with error.
    - Otherwise: perform the access, register PRDATA/PSLVERR, set PREADY<=1, → RESP.
  - RESP: PREADY=1 for exactly one cycle, then PREADY<=0 and → IDLE; the wait counter clears.
- TX push: tx_data[c] loaded with PWDATA[11:0] and tx_push[c]=1 in the RESP cycle; tx_data holds until the next push.
- RX pop: PRDATA captures rx_data[c] in the ACCESS-decision edge; rx_pop[c]=1 in the RESP cycle.
- Read-only sources are sampled on the ACCESS-decision edge. PRDATA changes only on read completions.
- IRQ_STATUS bit sets when the matching ch_event bit is 1. A write of 1 clears the bit. A set on the same edge as a clear wins.
- irq <= |(IRQ_STATUS & IRQ_MASK) over all channels, one cycle after the status/mask change.

## Timing
- Reset values: PRDATA=0, PREADY=0, PSLVERR=0, reg_command=0, tx_data=0, tx_push=0, rx_pop=0, reg_id_data=0, IRQ_STATUS=0, IRQ_MASK=0, irq=0, FSM=IDLE.
- PRESET during any state forces reset values on the next edge; no pending push/pop is emitted.
- Unstalled transfer takes 3 cycles (setup, access, PREADY=1 completion). Back-to-back: the next setup is accepted the cycle after completion.
- Stalled transfer completes at most WAIT_MAX cycles beyond unstalled. If tx_full/rx_empty deasserts on cycle k<WAIT_MAX, completion is successful on cycle k+1.
- Write data takes effect on the RESP-cycle edge, visible to a read in the following transfer.

## Test plan
- Reset, then write COMMAND ch1 = 0xA5 (PADDR=0x10) → PREADY on cycle 3, PSLVERR=0, reg_command[15:8]=0xA5, ch0 still 0x00.
- TX write 0x123 to ch0 with tx_full=0 → tx_push[0] single pulse coincident with PREADY, tx_data[11:0]=0x123. Repeat with tx_full held 1, WAIT_MAX=15 → PSLVERR=1 after 15 stall cycles, no push.
- RX read ch0 with rx_empty=1 for 4 cycles, then 0 with rx_data=0xABC → PREADY 1 cycle after release, PRDATA=0xABC, rx_pop[0] one pulse.
- Access PADDR=0x20 with CHANNELS=2, offset 9, and write to STATUS → each completes with PSLVERR=1, reads return 0, no state change.
- Pulse ch_event[2] on ch1, IRQ_MASK ch1=0x04 → irq=1 next cycle. W1C 0x04 on the same edge as a new event → bit stays set. Clear without an event → irq=0.
- Assert PRESET during a stalled TX access → PREADY, tx_push and irq all 0; FSM accepts a fresh setup on the first cycle after reset.

Source files
------------

// File: rtl/apb_sent_regbank.sv
// APB3 register bank for a multi-channel SENT controller: per-channel command,
// TX/RX FIFO access with wait-state back-pressure, and maskable W1C interrupts.
module apb_sent_regbank #(
    parameter int ADDRESSWIDTH = 8,
    parameter int DATAWIDTH    = 24,
    parameter int CHANNELS     = 2,
    parameter int WAIT_MAX     = 15
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic [ADDRESSWIDTH-1:0]   PADDR,
    input  logic [DATAWIDTH-1:0]      PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSELx,
    input  logic                      PENABLE,
    output logic [DATAWIDTH-1:0]      PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic [CHANNELS*8-1:0]     reg_command,
    input  logic [CHANNELS*8-1:0]     reg_status,
    output logic [CHANNELS*12-1:0]    tx_data,
    output logic [CHANNELS-1:0]       tx_push,
    input  logic [CHANNELS-1:0]       tx_full,
    input  logic [CHANNELS*12-1:0]    rx_data,
    input  logic [CHANNELS-1:0]       rx_empty,
    output logic [CHANNELS-1:0]       rx_pop,
    output logic [CHANNELS*24-1:0]    reg_id_data,
    input  logic [CHANNELS*24-1:0]    reg_id_data_rv,
    input  logic [CHANNELS*8-1:0]     reg_format_rv,
    input  logic [CHANNELS*8-1:0]     ch_event,
    output logic                      irq
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int IW = ADDRESSWIDTH - 4;

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
    state_t state, state_next;

    logic [7:0]            wait_cnt;
    logic [IW-1:0]         chan_full;
    logic [3:0]            offset;
    logic [CW-1:0]         ch;
    logic                  chan_ok, err_dec, is_tx, is_rx, active, stall, timeout, done, w1c;
    logic [DATAWIDTH-1:0]  rd_val;
    logic [CHANNELS*8-1:0] irq_status, irq_status_next, irq_mask;
    logic [CHANNELS-1:0]   push_sel, pop_sel;

    assign chan_full = PADDR[ADDRESSWIDTH-1:4];
    assign offset    = PADDR[3:0];
    assign ch        = chan_full[CW-1:0];
    assign chan_ok   = (chan_full < IW'(CHANNELS));

    always_comb begin
        err_dec = 1'b0;
        if (!chan_ok) begin
            err_dec = 1'b1;
        end else begin
            case (offset)
                4'd0, 4'd4, 4'd7, 4'd8: err_dec = 1'b0;
                4'd1, 4'd3, 4'd5, 4'd6: err_dec = PWRITE;
                4'd2:                   err_dec = !PWRITE;
                default:                err_dec = 1'b1;
            endcase
        end
    end

    // Only legal FIFO accesses can stall; decode errors complete immediately.
    assign is_tx   = !err_dec && PWRITE && (offset == 4'd2);
    assign is_rx   = !err_dec && !PWRITE && (offset == 4'd3);
    assign active  = (state == ACCESS) && PSELx && PENABLE;
    assign stall   = (is_tx && tx_full[ch]) || (is_rx && rx_empty[ch]);
    assign timeout = stall && (wait_cnt == 8'(WAIT_MAX));
    assign done    = active && (!stall || timeout);
    assign w1c     = done && !err_dec && !timeout && PWRITE && (offset == 4'd7);

    always_comb begin
        rd_val = '0;
        case (offset)
            4'd0: rd_val = DATAWIDTH'(reg_command[ch*8 +: 8]);
            4'd1: rd_val = DATAWIDTH'(reg_status[ch*8 +: 8]);
            4'd3: rd_val = DATAWIDTH'(rx_data[ch*12 +: 12]);
            4'd4: rd_val = DATAWIDTH'(reg_id_data[ch*24 +: 24]);
            4'd5: rd_val = DATAWIDTH'(reg_id_data_rv[ch*24 +: 24]);
            4'd6: rd_val = DATAWIDTH'(reg_format_rv[ch*8 +: 8]);
            4'd7: rd_val = DATAWIDTH'(irq_status[ch*8 +: 8]);
            4'd8: rd_val = DATAWIDTH'(irq_mask[ch*8 +: 8]);
            default: rd_val = '0;
        endcase
    end

    // A new event on the same edge as a write-1-to-clear keeps the bit set.
    always_comb begin
        irq_status_next = irq_status | ch_event;
        if (w1c)
            irq_status_next[ch*8 +: 8] = (irq_status[ch*8 +: 8] & ~PWDATA[7:0]) | ch_event[ch*8 +: 8];
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (PSELx && !PENABLE) state_next = ACCESS;
            ACCESS:  if (!(PSELx && PENABLE)) state_next = IDLE;
                     else if (done)           state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        PREADY  = (state == RESP);
        tx_push = (state == RESP) ? push_sel : '0;
        rx_pop  = (state == RESP) ? pop_sel  : '0;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wait_cnt    <= '0;
            PRDATA      <= '0;
            PSLVERR     <= 1'b0;
            reg_command <= '0;
            tx_data     <= '0;
            reg_id_data <= '0;
            irq_status  <= '0;
            irq_mask    <= '0;
            irq         <= 1'b0;
            push_sel    <= '0;
            pop_sel     <= '0;
        end else begin
            irq_status <= irq_status_next;
            irq        <= |(irq_status & irq_mask);
            if (active && stall && !timeout) wait_cnt <= wait_cnt + 8'd1;
            else if (!active)                wait_cnt <= '0;
            if (state == RESP) begin
                PSLVERR  <= 1'b0;
                push_sel <= '0;
                pop_sel  <= '0;
            end
            if (done) begin
                PSLVERR <= err_dec || timeout;
                if (!PWRITE) PRDATA <= (err_dec || timeout) ? '0 : rd_val;
                if (!err_dec && !timeout && PWRITE) begin
                    case (offset)
                        4'd0: reg_command[ch*8 +: 8] <= PWDATA[7:0];
                        4'd2: begin
                            tx_data[ch*12 +: 12] <= PWDATA[11:0];
                            push_sel[ch]         <= 1'b1;
                        end
                        4'd4: reg_id_data[ch*24 +: 24] <= PWDATA[23:0];
                        4'd8: irq_mask[ch*8 +: 8]      <= PWDATA[7:0];
                        default: ;
                    endcase
                end
                if (is_rx && !timeout) pop_sel[ch] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_apb_sent_regbank.sv
// Directed bench for apb_sent_regbank: register access, FIFO back-pressure,
// error decode, interrupt status/mask and mid-transfer reset.
module tb_apb_sent_regbank;
    logic        PCLK, PRESET;
    logic [7:0]  PADDR;
    logic [23:0] PWDATA, PRDATA;
    logic        PWRITE, PSELx, PENABLE, PREADY, PSLVERR, irq;
    logic [15:0] reg_command, reg_status, reg_format_rv, ch_event;
    logic [23:0] tx_data, rx_data;
    logic [1:0]  tx_push, tx_full, rx_empty, rx_pop;
    logic [47:0] reg_id_data, reg_id_data_rv;

    int total = 0;
    int bad   = 0;
    int push_cnt = 0;
    int pop_cnt  = 0;
    logic [1:0] last_push, last_pop;

    apb_sent_regbank #(.ADDRESSWIDTH(8), .DATAWIDTH(24), .CHANNELS(2), .WAIT_MAX(15)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
        .PSELx(PSELx), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .reg_command(reg_command), .reg_status(reg_status), .tx_data(tx_data), .tx_push(tx_push),
        .tx_full(tx_full), .rx_data(rx_data), .rx_empty(rx_empty), .rx_pop(rx_pop),
        .reg_id_data(reg_id_data), .reg_id_data_rv(reg_id_data_rv), .reg_format_rv(reg_format_rv),
        .ch_event(ch_event), .irq(irq)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    always @(negedge PCLK) begin
        push_cnt += int'(tx_push[0]) + int'(tx_push[1]);
        pop_cnt  += int'(rx_pop[0]) + int'(rx_pop[1]);
    end

    // Called 1ns after an edge; returns 1ns after the edge following the PREADY cycle.
    task automatic apb_xfer(input logic [7:0] addr, input logic wr, input logic [23:0] wd,
                            output logic [23:0] rd, output logic err, output int waits);
        PADDR = addr; PWRITE = wr; PWDATA = wd; PSELx = 1'b1; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        waits = 0;
        do begin
            @(posedge PCLK); #1;
            waits++;
        end while (!PREADY && waits < 40);
        rd = PRDATA; err = PSLVERR; last_push = tx_push; last_pop = rx_pop;
        @(posedge PCLK); #1;
        PSELx = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic test_reset();
        PRESET = 1'b1;
        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b0;
        total++; if (PREADY !== 1'b0 || PSLVERR !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b/%b want 0/0", PREADY, PSLVERR); end
        total++; if (PRDATA !== 24'h0) begin bad++; $display("FAIL reset_prdata: got %h want 000000", PRDATA); end
        total++; if (reg_command !== 16'h0 || tx_data !== 24'h0 || reg_id_data !== 48'h0) begin bad++; $display("FAIL reset_regs: got %h %h %h want 0", reg_command, tx_data, reg_id_data); end
        total++; if (tx_push !== 2'b00 || rx_pop !== 2'b00 || irq !== 1'b0) begin bad++; $display("FAIL reset_strobes: got %b %b %b want 0", tx_push, rx_pop, irq); end
    endtask

    task automatic test_command();
        logic [23:0] rd; logic err; int w;
        apb_xfer(8'h10, 1'b1, 24'h0000A5, rd, err, w);
        total++; if (w !== 1 || err !== 1'b0) begin bad++; $display("FAIL cmd_write: got waits=%0d err=%b want 1/0", w, err); end
        total++; if (reg_command !== 16'hA500) begin bad++; $display("FAIL cmd_value: got %h want A500", reg_command); end
        apb_xfer(8'h10, 1'b0, 24'h0, rd, err, w);
        total++; if (rd !== 24'h0000A5 || err !== 1'b0) begin bad++; $display("FAIL cmd_read: got %h err=%b want 0000A5/0", rd, err); end
        apb_xfer(8'h00, 1'b0, 24'h0, rd, err, w);
        total++; if (rd !== 24'h0) begin bad++; $display("FAIL cmd_read_ch0: got %h want 000000", rd); end
    endtask

    task automatic test_back_to_back();
        logic [23:0] rd; logic err; int w, w2;
        apb_xfer(8'h14, 1'b1, 24'h123456, rd, err, w);
        apb_xfer(8'h14, 1'b0, 24'h0, rd, err, w2);
        total++; if (w !== 1 || w2 !== 1) begin bad++; $display("FAIL b2b_waits: got %0d/%0d want 1/1", w, w2); end
        total++; if (rd !== 24'h123456 || reg_id_data !== 48'h123456_000000) begin bad++; $display("FAIL b2b_iddata: got %h %h want 123456", rd, reg_id_data); end
    endtask

    task automatic test_tx();
        logic [23:0] rd; logic err; int w, p0;
        tx_full = 2'b00; p0 = push_cnt;
        apb_xfer(8'h02, 1'b1, 24'h000123, rd, err, w);
        total++; if (w !== 1 || err !== 1'b0 || last_push !== 2'b01) begin bad++; $display("FAIL tx_push: got waits=%0d err=%b push=%b want 1/0/01", w, err, last_push); end
        total++; if (tx_data[11:0] !== 12'h123 || push_cnt !== p0 + 1) begin bad++; $display("FAIL tx_data: got %h pulses=%0d want 123/%0d", tx_data[11:0], push_cnt, p0 + 1); end
        tx_full = 2'b01;
        apb_xfer(8'h02, 1'b1, 24'h000456, rd, err, w);
        total++; if (w !== 16 || err !== 1'b1 || last_push !== 2'b00) begin bad++; $display("FAIL tx_timeout: got waits=%0d err=%b push=%b want 16/1/00", w, err, last_push); end
        total++; if (tx_data[11:0] !== 12'h123 || push_cnt !== p0 + 1) begin bad++; $display("FAIL tx_timeout_noeffect: got %h pulses=%0d want 123/%0d", tx_data[11:0], push_cnt, p0 + 1); end
        apb_xfer(8'h12, 1'b1, 24'h0007EF, rd, err, w);
        total++; if (w !== 1 || last_push !== 2'b10 || tx_data !== 24'h7EF123) begin bad++; $display("FAIL tx_ch1: got waits=%0d push=%b data=%h want 1/10/7EF123", w, last_push, tx_data); end
        tx_full = 2'b00;
    endtask

    task automatic test_rx();
        logic [23:0] rd; logic err; int w, p0;
        p0 = pop_cnt;
        rx_empty = 2'b01; rx_data = 24'h000111;
        PADDR = 8'h03; PWRITE = 1'b0; PSELx = 1'b1; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        repeat (4) @(posedge PCLK);
        #1;
        total++; if (PREADY !== 1'b0) begin bad++; $display("FAIL rx_stall: got PREADY=%b want 0", PREADY); end
        rx_empty = 2'b00; rx_data = 24'h000ABC;
        @(posedge PCLK); #1;
        total++; if (PREADY !== 1'b1 || PSLVERR !== 1'b0 || PRDATA !== 24'h000ABC || rx_pop !== 2'b01) begin bad++; $display("FAIL rx_release: got rdy=%b err=%b data=%h pop=%b want 1/0/000ABC/01", PREADY, PSLVERR, PRDATA, rx_pop); end
        @(posedge PCLK); #1;
        PSELx = 1'b0; PENABLE = 1'b0;
        total++; if (PREADY !== 1'b0 || pop_cnt !== p0 + 1) begin bad++; $display("FAIL rx_pulse: got rdy=%b pulses=%0d want 0/%0d", PREADY, pop_cnt, p0 + 1); end
        rx_empty = 2'b10;
        apb_xfer(8'h13, 1'b0, 24'h0, rd, err, w);
        total++; if (w !== 16 || err !== 1'b1 || rd !== 24'h0 || last_pop !== 2'b00) begin bad++; $display("FAIL rx_timeout: got waits=%0d err=%b data=%h pop=%b want 16/1/0/00", w, err, rd, last_pop); end
        rx_empty = 2'b00;
    endtask

    task automatic test_readonly();
        logic [23:0] rd; logic err; int w;
        reg_status = 16'h5A3C; reg_id_data_rv = 48'h654321_FEDCBA; reg_format_rv = 16'h9A5B;
        apb_xfer(8'h01, 1'b0, 24'h0, rd, err, w);
        total++; if (rd !== 24'h00003C || err !== 1'b0) begin bad++; $display("FAIL ro_status: got %h err=%b want 00003C/0", rd, err); end
        apb_xfer(8'h15, 1'b0, 24'h0, rd, err, w);
        total++; if (rd !== 24'h654321) begin bad++; $display("FAIL ro_idrv: got %h want 654321", rd); end
        apb_xfer(8'h06, 1'b0, 24'h0, rd, err, w);
        total++; if (rd !== 24'h00005B) begin bad++; $display("FAIL ro_format: got %h want 00005B", rd); end
    endtask

    task automatic test_errors();
        logic [23:0] rd; logic err; int w;
        apb_xfer(8'h20, 1'b0, 24'h0, rd, err, w);
        total++; if (err !== 1'b1 || rd !== 24'h0 || w !== 1) begin bad++; $display("FAIL err_chan_read: got err=%b data=%h waits=%0d want 1/0/1", err, rd, w); end
        apb_xfer(8'h20, 1'b1, 24'h0000FF, rd, err, w);
        total++; if (err !== 1'b1 || reg_command !== 16'hA500) begin bad++; $display("FAIL err_chan_write: got err=%b cmd=%h want 1/A500", err, reg_command); end
        apb_xfer(8'h09, 1'b0, 24'h0, rd, err, w);
        total++; if (err !== 1'b1 || rd !== 24'h0) begin bad++; $display("FAIL err_unmapped: got err=%b data=%h want 1/0", err, rd); end
        apb_xfer(8'h01, 1'b1, 24'h000077, rd, err, w);
        total++; if (err !== 1'b1 || reg_command !== 16'hA500) begin bad++; $display("FAIL err_ro_write: got err=%b cmd=%h want 1/A500", err, reg_command); end
        apb_xfer(8'h02, 1'b0, 24'h0, rd, err, w);
        total++; if (err !== 1'b1 || rd !== 24'h0 || last_pop !== 2'b00) begin bad++; $display("FAIL err_tx_read: got err=%b data=%h pop=%b want 1/0/00", err, rd, last_pop); end
    endtask

    task automatic test_irq();
        logic [23:0] rd; logic err; int w;
        apb_xfer(8'h18, 1'b1, 24'h000004, rd, err, w);
        ch_event = 16'h0400;
        @(posedge PCLK); #1;
        ch_event = 16'h0000;
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_latency: got %b want 0", irq); end
        @(posedge PCLK); #1;
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_set: got %b want 1", irq); end
        // W1C on the same edge as a new event
        PADDR = 8'h17; PWRITE = 1'b1; PWDATA = 24'h000004; PSELx = 1'b1; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1; ch_event = 16'h0400;
        @(posedge PCLK); #1;
        ch_event = 16'h0000;
        @(posedge PCLK); #1;
        PSELx = 1'b0; PENABLE = 1'b0;
        apb_xfer(8'h17, 1'b0, 24'h0, rd, err, w);
        total++; if (rd !== 24'h000004 || irq !== 1'b1) begin bad++; $display("FAIL irq_set_wins: got status=%h irq=%b want 000004/1", rd, irq); end
        apb_xfer(8'h17, 1'b1, 24'h000004, rd, err, w);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear: got %b want 0", irq); end
        ch_event = 16'h0001;
        @(posedge PCLK); #1;
        ch_event = 16'h0000;
        repeat (2) @(posedge PCLK);
        #1;
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_masked: got %b want 0", irq); end
        apb_xfer(8'h07, 1'b0, 24'h0, rd, err, w);
        total++; if (rd !== 24'h000001) begin bad++; $display("FAIL irq_status_ch0: got %h want 000001", rd); end
    endtask

    task automatic test_reset_mid();
        logic [23:0] rd; logic err; int w, p0;
        ch_event = 16'h0400;
        @(posedge PCLK); #1;
        ch_event = 16'h0000;
        repeat (2) @(posedge PCLK);
        #1;
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL rstmid_irq_pre: got %b want 1", irq); end
        p0 = push_cnt;
        tx_full = 2'b01;
        PADDR = 8'h02; PWRITE = 1'b1; PWDATA = 24'h000999; PSELx = 1'b1; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b0; PSELx = 1'b0; PENABLE = 1'b0; tx_full = 2'b00;
        total++; if (PREADY !== 1'b0 || tx_push !== 2'b00 || irq !== 1'b0) begin bad++; $display("FAIL rstmid_outputs: got rdy=%b push=%b irq=%b want 0/00/0", PREADY, tx_push, irq); end
        apb_xfer(8'h00, 1'b1, 24'h00003C, rd, err, w);
        total++; if (w !== 1 || err !== 1'b0 || reg_command !== 16'h003C) begin bad++; $display("FAIL rstmid_fresh: got waits=%0d err=%b cmd=%h want 1/0/003C", w, err, reg_command); end
        total++; if (push_cnt !== p0 || tx_data !== 24'h0) begin bad++; $display("FAIL rstmid_nopush: got pulses=%0d data=%h want %0d/0", push_cnt, tx_data, p0); end
    endtask

    initial begin
        PRESET = 1'b0; PADDR = '0; PWDATA = '0; PWRITE = 1'b0; PSELx = 1'b0; PENABLE = 1'b0;
        reg_status = '0; tx_full = '0; rx_data = '0; rx_empty = '0;
        reg_id_data_rv = '0; reg_format_rv = '0; ch_event = '0;
        last_push = '0; last_pop = '0;
        @(posedge PCLK); #1;
        test_reset();
        test_command();
        test_back_to_back();
        test_tx();
        test_rx();
        test_readonly();
        test_errors();
        test_irq();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
